// File: rtl/cnn_seq_pkg.sv
// Shared types and constants for the CNN frame sequencer.
//   seq_state_e      : sequencer FSM states
//   seq_result_t     : captured per-job result payload
//   IMG_PIXELS_DEF   : default pixels per image (28x28)
//   TIMEOUT_DECISION : decision code reported when the chip never answers
package cnn_seq_pkg;

  localparam int unsigned IMG_PIXELS_DEF   = 784;
  localparam logic [3:0]  TIMEOUT_DECISION = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    STREAM,
    WAIT,
    REPORT
  } seq_state_e;

  typedef struct packed {
    logic [3:0] decision;
    logic [3:0] label;
    logic       hit;
    logic       timeout;
  } seq_result_t;

endpackage

// File: rtl/cnn_frame_sequencer_if.sv
// Job/result handshake bundle between the host queue and the sequencer.
//   start_* : job offer (valid/ready, image index, expected label)
//   res_*   : result report (valid/ready, decision, label, hit, timeout)
//   master  : host side, slave : sequencer side
interface cnn_frame_sequencer_if #(
  parameter int unsigned IDX_W = 10
);
  logic             start_valid;
  logic             start_ready;
  logic [IDX_W-1:0] start_idx;
  logic [3:0]       start_label;

  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_decision;
  logic [3:0]       res_label;
  logic             res_hit;
  logic             res_timeout;

  modport master (
    output start_valid, start_idx, start_label, res_ready,
    input  start_ready, res_valid, res_decision, res_label, res_hit, res_timeout
  );

  modport slave (
    input  start_valid, start_idx, start_label, res_ready,
    output start_ready, res_valid, res_decision, res_label, res_hit, res_timeout
  );
endinterface

// File: rtl/cnn_pixel_streamer.sv
// Address generator plus one-stage read pipeline that moves one image from
// the synchronous pixel memory to the chip, one byte per cycle.
//   start     : one-cycle pulse, begin issuing reads at base
//   base      : first pixel address of the image
//   mem_*     : pixel memory read port (rdata valid the cycle after rd_en)
//   data_out  : registered pixel byte to the chip, holds the last byte
//   done_c    : high in the cycle the last byte is being loaded into data_out
module cnn_pixel_streamer #(
  parameter int unsigned IMG_PIXELS = 784,
  parameter int unsigned ADDR_W     = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        data_out,
  output logic              done_c
);
  localparam int unsigned PIX_W = $clog2(IMG_PIXELS);

  logic [PIX_W-1:0] pix_q;
  logic             rdata_vld_q;
  logic             rdata_last_q;

  // Read issue and return pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_rd_en    <= 1'b0;
      mem_addr     <= '0;
      pix_q        <= '0;
      rdata_vld_q  <= 1'b0;
      rdata_last_q <= 1'b0;
      data_out     <= '0;
    end else begin
      rdata_vld_q  <= mem_rd_en;
      rdata_last_q <= mem_rd_en && (pix_q == PIX_W'(IMG_PIXELS - 1));
      if (rdata_vld_q) data_out <= mem_rdata;
      if (start) begin
        mem_rd_en <= 1'b1;
        mem_addr  <= base;
        pix_q     <= '0;
      end else if (mem_rd_en) begin
        if (pix_q == PIX_W'(IMG_PIXELS - 1)) begin
          mem_rd_en <= 1'b0;
        end else begin
          mem_addr <= mem_addr + ADDR_W'(1);
          pix_q    <= pix_q + PIX_W'(1);
        end
      end
    end
  end

  assign done_c = rdata_last_q;

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Runs the CNN chip over a queue of images: accept job, pulse the chip reset,
// stream the image, wait for a decision (or time out), report and count.
//   clk, rst_n      : clock, synchronous active-low reset
//   bus (slave)     : job offer and result report handshakes
//   mem_*           : pixel memory read port
//   cnn_*           : chip reset, pixel data, decision strobe/value
//   hit_count       : saturating hit total, img_count : saturating job total
//   busy            : sequencer not idle
// Optional build macro CNN_SEQ_LATENCY_EN adds lat_max: longest decision wait
// (WAIT cycles) over non-timeout jobs.
module cnn_frame_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int unsigned IMG_PIXELS = IMG_PIXELS_DEF,
  parameter int unsigned IDX_W      = 10,
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 4095
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cnn_frame_sequencer_if.slave  bus,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic                  cnn_rst_n,
  output logic [7:0]            cnn_data_in,
  input  logic                  cnn_valid_out,
  input  logic [3:0]            cnn_decision,
  output logic [CNT_W-1:0]      hit_count,
  output logic [CNT_W-1:0]      img_count,
  output logic                  busy
`ifdef CNN_SEQ_LATENCY_EN
  ,
  output logic [12:0]           lat_max
`endif
);
  localparam int unsigned TMR_W = 13;
  localparam int unsigned CLR_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  seq_state_e        state_q, state_d;
  logic [3:0]        label_q, label_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  seq_result_t       res_q, res_d;
  logic              res_valid_q, res_valid_d;
  logic [CNT_W-1:0]  hit_q, hit_d;
  logic [CNT_W-1:0]  img_q, img_d;
  logic              cnn_rst_n_q;
  logic              busy_q;
  logic              stream_start_c;
  logic              stream_done_c;
`ifdef CNN_SEQ_LATENCY_EN
  logic [12:0]       lat_q, lat_d;
`endif

  assign stream_start_c = (state_q == CLR) && (clr_cnt_q == CLR_W'(RST_CYCLES - 1));

  cnn_pixel_streamer #(
    .IMG_PIXELS (IMG_PIXELS),
    .ADDR_W     (ADDR_W)
  ) u_streamer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (stream_start_c),
    .base      (base_q),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .data_out  (cnn_data_in),
    .done_c    (stream_done_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    label_d     = label_q;
    base_d      = base_q;
    clr_cnt_d   = clr_cnt_q;
    timer_d     = timer_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    hit_d       = hit_q;
    img_d       = img_q;
`ifdef CNN_SEQ_LATENCY_EN
    lat_d       = lat_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          label_d   = bus.start_label;
          base_d    = ADDR_W'(bus.start_idx) * ADDR_W'(IMG_PIXELS);
          clr_cnt_d = '0;
          state_d   = CLR;
        end
      end
      CLR: begin
        if (stream_start_c) state_d = STREAM;
        else                clr_cnt_d = clr_cnt_q + CLR_W'(1);
      end
      STREAM: begin
        // Decision strobes here are left over from the previous frame.
        if (stream_done_c) begin
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // A strobe on the expiry cycle wins over the timeout.
        if (cnn_valid_out) begin
          res_d.decision = cnn_decision;
          res_d.label    = label_q;
          res_d.hit      = (cnn_decision == label_q);
          res_d.timeout  = 1'b0;
          res_valid_d    = 1'b1;
          state_d        = REPORT;
`ifdef CNN_SEQ_LATENCY_EN
          if (13'(timer_q + TMR_W'(1)) > lat_q) lat_d = 13'(timer_q + TMR_W'(1));
`endif
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          res_d.decision = TIMEOUT_DECISION;
          res_d.label    = label_q;
          res_d.hit      = 1'b0;
          res_d.timeout  = 1'b1;
          res_valid_d    = 1'b1;
          state_d        = REPORT;
        end
      end
      REPORT: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          if (!(&img_q))              img_d = img_q + CNT_W'(1);
          if (res_q.hit && !(&hit_q)) hit_d = hit_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      label_q     <= '0;
      base_q      <= '0;
      clr_cnt_q   <= '0;
      timer_q     <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      hit_q       <= '0;
      img_q       <= '0;
      cnn_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CNN_SEQ_LATENCY_EN
      lat_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      label_q     <= label_d;
      base_q      <= base_d;
      clr_cnt_q   <= clr_cnt_d;
      timer_q     <= timer_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      hit_q       <= hit_d;
      img_q       <= img_d;
      cnn_rst_n_q <= (state_d != CLR);
      busy_q      <= (state_d != IDLE);
`ifdef CNN_SEQ_LATENCY_EN
      lat_q       <= lat_d;
`endif
    end
  end

  assign bus.start_ready  = (state_q == IDLE);
  assign bus.res_valid    = res_valid_q;
  assign bus.res_decision = res_q.decision;
  assign bus.res_label    = res_q.label;
  assign bus.res_hit      = res_q.hit;
  assign bus.res_timeout  = res_q.timeout;
  assign cnn_rst_n        = cnn_rst_n_q;
  assign hit_count        = hit_q;
  assign img_count        = img_q;
  assign busy             = busy_q;
`ifdef CNN_SEQ_LATENCY_EN
  assign lat_max          = lat_q;
`endif

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Scoreboard bench for cnn_frame_sequencer: jobs push expected results,
// a monitor pops them as results appear; a stream checker and chip model
// watch the memory/chip side.
module tb_cnn_frame_sequencer;
  localparam int unsigned IMG_PIXELS = 784;
  localparam int unsigned IDX_W      = 10;
  localparam int unsigned ADDR_W     = 20;
  localparam int unsigned CNT_W      = 10;
  localparam int unsigned RST_CYCLES = 2;
  localparam int unsigned TIMEOUT    = 4095;
  localparam int          CLK_P      = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cnn_frame_sequencer_if #(.IDX_W(IDX_W)) bus ();

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata = 8'h00;
  logic              cnn_rst_n;
  logic [7:0]        cnn_data_in;
  logic              cnn_valid_out = 1'b0;
  logic [3:0]        cnn_decision = 4'h0;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  img_count;
  logic              busy;
`ifdef CNN_SEQ_LATENCY_EN
  logic [12:0]       lat_max;
`endif

  cnn_frame_sequencer #(
    .IMG_PIXELS (IMG_PIXELS),
    .IDX_W      (IDX_W),
    .ADDR_W     (ADDR_W),
    .CNT_W      (CNT_W),
    .RST_CYCLES (RST_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .cnn_rst_n     (cnn_rst_n),
    .cnn_data_in   (cnn_data_in),
    .cnn_valid_out (cnn_valid_out),
    .cnn_decision  (cnn_decision),
    .hit_count     (hit_count),
    .img_count     (img_count),
    .busy          (busy)
`ifdef CNN_SEQ_LATENCY_EN
    ,
    .lat_max       (lat_max)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
  endtask

  task automatic bail(input string what);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", what);
    summary();
    $finish;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory: each byte is the low 8 bits of its address, one-cycle read latency.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_addr[7:0];

  // Per-job chip behaviour, set by the stimulus before each job.
  int         exp_base   = 0;
  int         chip_delay = -1;
  logic [3:0] chip_dec   = 4'h0;
  int         spur_at    = -1;

  // Stream checker state and chip model.
  int          pix_rd  = 0;
  int          pix_dat = 0;
  int          rel     = -1;
  int          low_cnt = 0;
  bit          rd_h1 = 1'b0, rd_h2 = 1'b0;
  logic [ADDR_W-1:0] a_h1 = '0, a_h2 = '0;
  time         last_t = 0;

  always @(negedge clk) begin
    cnn_valid_out = 1'b0;
    if (!rst_n) begin
      pix_rd = 0; pix_dat = 0; rel = -1; low_cnt = 0;
      rd_h1 = 1'b0; rd_h2 = 1'b0;
    end else begin
      // byte read two samples ago must now be on the chip input
      if (rd_h2) begin
        chk("cnn_data_in", cnn_data_in, a_h2[7:0]);
        pix_dat++;
        if (pix_dat == IMG_PIXELS) begin
          pix_dat = 0;
          rel     = 0;
          last_t  = $time;
        end
      end
      if (mem_rd_en) begin
        chk("mem_addr", mem_addr, exp_base + pix_rd);
        if (pix_rd == spur_at) begin
          cnn_valid_out = 1'b1;
          cnn_decision  = chip_dec ^ 4'h1;
        end
        pix_rd++;
        if (pix_rd == IMG_PIXELS) pix_rd = 0;
      end
      if (rel >= 0) begin
        if (rel == chip_delay) begin
          cnn_valid_out = 1'b1;
          cnn_decision  = chip_dec;
          rel = -1;
        end else if (rel > int'(TIMEOUT) + 4) begin
          rel = -1;
        end else begin
          rel++;
        end
      end
      if (busy && !cnn_rst_n) begin
        low_cnt++;
      end else if (low_cnt != 0) begin
        chk("cnn_rst_n_low_cycles", low_cnt, RST_CYCLES);
        low_cnt = 0;
      end
      rd_h2 = rd_h1; a_h2 = a_h1;
      rd_h1 = mem_rd_en; a_h1 = mem_addr;
    end
  end

  // Scoreboard
  typedef struct {
    logic [3:0] dec;
    logic [3:0] label;
    logic       hit;
    logic       tmo;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   seen = 1'b0;
  bit   hs_pend = 1'b0;
  int   exp_hits = 0;
  int   exp_imgs = 0;
  int   exp_lat_max = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      seen = 1'b0; hs_pend = 1'b0;
      exp_hits = 0; exp_imgs = 0; exp_lat_max = 0;
    end else begin
      if (hs_pend) begin
        chk("res_valid_drop", bus.res_valid, 0);
        chk("hit_count", hit_count, exp_hits);
        chk("img_count", img_count, exp_imgs);
        hs_pend = 1'b0;
        seen    = 1'b0;
      end else if (bus.res_valid && !seen) begin
        chk("result_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cur  = exp_q.pop_front();
          seen = 1'b1;
          chk("res_decision", bus.res_decision, cur.dec);
          chk("res_label", bus.res_label, cur.label);
          chk("res_hit", bus.res_hit, cur.hit);
          chk("res_timeout", bus.res_timeout, cur.tmo);
          chk("wait_cycles", ($time - last_t) / CLK_P, cur.lat);
`ifdef CNN_SEQ_LATENCY_EN
          if (!cur.tmo && cur.lat > exp_lat_max) exp_lat_max = cur.lat;
          chk("lat_max", lat_max, exp_lat_max);
`endif
        end
      end else if (bus.res_valid && seen) begin
        chk("res_stable", {bus.res_decision, bus.res_label, bus.res_hit, bus.res_timeout},
            {cur.dec, cur.label, cur.hit, cur.tmo});
      end
      if (bus.res_valid && bus.res_ready && seen && !hs_pend) begin
        hs_pend = 1'b1;
        if (exp_imgs < (1 << CNT_W) - 1) exp_imgs++;
        if (cur.hit && exp_hits < (1 << CNT_W) - 1) exp_hits++;
      end
    end
  end

  // Stimulus helpers
  task automatic prep_job(input int idx, input int label, input int dec, input int delay, input int spur);
    exp_t e;
    exp_base   = idx * int'(IMG_PIXELS);
    chip_delay = delay;
    chip_dec   = 4'(dec);
    spur_at    = spur;
    e.tmo   = (delay < 0);
    e.dec   = e.tmo ? 4'hF : 4'(dec);
    e.label = 4'(label);
    e.hit   = !e.tmo && (dec == label);
    e.lat   = e.tmo ? int'(TIMEOUT) : delay + 1;
    exp_q.push_back(e);
    bus.start_valid = 1'b1;
    bus.start_idx   = IDX_W'(idx);
    bus.start_label = 4'(label);
  endtask

  task automatic wait_accept();
    int b = 0;
    while (!bus.start_ready) begin
      step();
      b++;
      if (b > 20000) bail("start_ready");
    end
    step();
    bus.start_valid = 1'b0;
  endtask

  task automatic wait_res();
    int b = 0;
    while (!bus.res_valid) begin
      step();
      b++;
      if (b > int'(TIMEOUT) + 3000) bail("res_valid");
    end
  endtask

  task automatic finish_res(input int hold);
    wait_res();
    repeat (hold) step();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
  endtask

  task automatic run_job(input int idx, input int label, input int dec, input int delay,
                         input int spur, input int hold);
    prep_job(idx, label, dec, delay, spur);
    wait_accept();
    finish_res(hold);
  endtask

  task automatic check_reset();
    chk("rst_start_ready", bus.start_ready, 1);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cnn_rst_n", cnn_rst_n, 0);
    chk("rst_cnn_data_in", cnn_data_in, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_fields", {bus.res_decision, bus.res_label, bus.res_hit, bus.res_timeout}, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_img_count", img_count, 0);
    chk("rst_busy", busy, 0);
`ifdef CNN_SEQ_LATENCY_EN
    chk("rst_lat_max", lat_max, 0);
`endif
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.start_idx   = '0;
    bus.start_label = '0;
    bus.res_ready   = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    check_reset();
    rst_n = 1'b1;
    step();
    chk("cnn_rst_n_idle", cnn_rst_n, 1);

    // hit, decision 20 cycles after the last pixel
    run_job(0, 7, 7, 20, -1, 0);
    // top-of-memory image, miss
    run_job(999, 3, 5, 20, -1, 0);
    // chip never answers
    run_job(int'($urandom_range(1023)), 1, 0, -1, -1, 0);
    // stale strobe mid-stream, real decision later
    run_job(int'($urandom_range(1023)), 4, 4, 35, 400, 0);
    // strobe lands on the expiry cycle
    run_job(int'($urandom_range(1023)), 2, 2, int'(TIMEOUT) - 1, -1, 1);

    // result held 50 cycles with the next job already offered
    prep_job(int'($urandom_range(1023)), 6, 6, 10, -1);
    wait_accept();
    wait_res();
    prep_job(int'($urandom_range(1023)), 9, 8, 15, -1);
    repeat (50) begin
      chk("start_ready_blocked", bus.start_ready, 0);
      step();
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("start_ready_after_hs", bus.start_ready, 1);
    step();
    bus.start_valid = 1'b0;
    chk("next_job_busy", busy, 1);
    chk("next_job_cnn_rst_n", cnn_rst_n, 0);
    finish_res(0);

    // reset in the middle of a frame
    prep_job(int'($urandom_range(1023)), 5, 5, 12, -1);
    wait_accept();
    begin
      int b = 0;
      while (pix_rd < 500) begin
        step();
        b++;
        if (b > 2000) bail("pixel 500");
      end
    end
    rst_n = 1'b0;
    step();
    check_reset();
    rst_n = 1'b1;
    step();
    run_job(int'($urandom_range(1023)), 8, 8, 7, -1, 0);

    // randomized jobs
    for (int j = 0; j < 4; j++) begin
      int idx = int'($urandom_range(1023));
      int lab = int'($urandom_range(9));
      int dec = ($urandom_range(1) == 1) ? lab : int'($urandom_range(9));
      int dly = int'($urandom_range(60));
      run_job(idx, lab, dec, dly, -1, int'($urandom_range(5)));
    end

    repeat (5) step();
    summary();
    $finish;
  end

endmodule
